sprite_mem_server: RTL and testbench
====================================

SPRITE_MEM_SERVER -- requirements
Module: sprite_mem_server

Interface
REQ-001 Parameters (name, default, meaning), one line each:
- ROM_AW, 19, pixel-store address width.
- BG_BASE, 0, pair offset, MEM_SEL 000.
- PWR_BASE, 64800, pair offset, 001.
- RED_BASE, 65000, pair offset, 010.
- GREEN_BASE, 79112, pair offset, 011.
- BLUE_BASE, 93224, pair offset, 100.
- YELLOW_BASE, 107336, pair offset, 101.
- WIN_BASE, 121448, pair offset, 110.
- LOSE_BASE, 143048, pair offset, 111.

REQ-002 Ports (name, direction, width, meaning), one line each:
- CLK, in, 1, single clock, all logic rising-edge.
- RESET_N, in, 1, asynchronous active-low reset.
- MEM_CLK, in, 1, pair-read request strobe from the sprite loader.
- MEM_ADDR, in, 16, pair index within the sprite.
- MEM_SEL, in, 3, sprite select.
- DATA_OUT, out, 48, pixel pair: [47:24] first pixel, [23:0] second pixel.
- DATA_VALID, out, 1, DATA_OUT holds the answer to the last accepted request.
- ROM_RD, out, 1, pixel-store read enable.
- ROM_ADDR, out, ROM_AW, pixel-store address.
- ROM_DATA, in, 24, pixel-store read data, 1-cycle latency after ROM_RD.
- ADDR_ERR, out, 1, sticky out-of-range flag.
- OVERRUN, out, 1, sticky request-while-busy flag.

Function
REQ-003 The block SHALL register MEM_CLK each CLK and detect a request as registered-low, current-high (rising edge).
REQ-004 FSM states SHALL be IDLE, RD_HI, RD_LO, CAP_LO.
REQ-005 Transitions SHALL be: IDLE -> RD_HI on request; RD_HI -> RD_LO; RD_LO -> CAP_LO; CAP_LO -> IDLE, all unconditional except the IDLE exit.
REQ-006 On the request edge the block SHALL latch MEM_ADDR and MEM_SEL, drop DATA_VALID, and hold DATA_OUT unchanged.
REQ-007 In RD_HI: ROM_RD=1, ROM_ADDR=2*(base(sel)+addr).
- In RD_LO: ROM_RD=1, ROM_ADDR=2*(base(sel)+addr)+1, and ROM_DATA is captured as the first pixel.
REQ-008 In CAP_LO the block SHALL load DATA_OUT={first pixel, ROM_DATA} and set DATA_VALID at the end of the cycle.
- Total latency from the request-edge sampling clock to DATA_VALID high: 4 CLK.
REQ-009 DATA_OUT and DATA_VALID SHALL remain stable until the next accepted request, since the loader samples in its wait states.
REQ-010 ROM address arithmetic SHALL be computed at ROM_AW bits with no truncation. The maximum legal value is 336495.
REQ-011 Range checks SHALL use these pair limits per sprite:
- BG 64800.
- PWR 200.
- RED/GREEN/BLUE/YELLOW 14112.
- WIN 21600.
- LOSE 25200.
REQ-012 A request with addr >= limit(sel) SHALL follow the same state sequence and timing with ROM_RD held 0, load DATA_OUT=0, and set ADDR_ERR.
REQ-013 A request edge in any state other than IDLE SHALL be ignored (no relatch) and SHALL set OVERRUN.
REQ-014 ADDR_ERR and OVERRUN SHALL clear only on reset.
REQ-015 ROM_RD SHALL be 0 in IDLE and CAP_LO.

Reset
REQ-016 While RESET_N=0, all of the following SHALL be forced immediately:
- FSM = IDLE.
- MEM_CLK history = 1, so a strobe held high through reset is not taken as a request.
- DATA_OUT = 0, DATA_VALID = 0.
- ROM_RD = 0, ROM_ADDR = 0.
- ADDR_ERR = 0, OVERRUN = 0.
REQ-017 Reset asserted mid-read SHALL abandon the read; the first request after release SHALL behave as from power-up.

Structure
REQ-018 A shared package SHALL hold:
- MEM_SEL encodings.
- Per-sprite pair limits.
- Per-sprite base offsets.
- FSM state encoding.
These are shared with the loader.
REQ-019 One sub-module is natural: sprite_addr_map. It is combinational (sel, addr) -> (pair base sum, in_range).

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- BG read: sel=000, addr=5, ROM[10]=0x112233, ROM[11]=0x445566 -> ROM_ADDR 10 then 11; DATA_OUT=0x112233445566 and DATA_VALID=1 at cycle 4.
- LOSE last pair: sel=111, addr=25199 -> ROM_ADDR 336494, 336495; data packed correctly.
- Out of range: sel=001, addr=200 -> ROM_RD never 1; DATA_OUT=0; ADDR_ERR=1 and stays 1.
- Overrun: second MEM_CLK edge in RD_LO -> addresses of the first request unaffected; OVERRUN=1; first data delivered.
- Reset mid-read: RESET_N low in RD_LO with MEM_CLK held high -> all outputs 0; no request after release until MEM_CLK falls and rises.
- Hold: DATA_VALID=1, MEM_CLK static for 100 CLK -> DATA_OUT unchanged.

Source files
------------

// File: rtl/sprite_mem_server_pkg.sv
// Shared definitions for the sprite memory server and the sprite loader.
// Holds the sprite select encodings, the base pair offset of each sprite in
// the pixel store, the number of pixel pairs in each sprite, and the server
// FSM state encoding.
package sprite_mem_server_pkg;

    typedef enum logic [2:0] {
        SEL_BG     = 3'b000,
        SEL_PWR    = 3'b001,
        SEL_RED    = 3'b010,
        SEL_GREEN  = 3'b011,
        SEL_BLUE   = 3'b100,
        SEL_YELLOW = 3'b101,
        SEL_WIN    = 3'b110,
        SEL_LOSE   = 3'b111
    } sprite_sel_e;

    // Base offsets, in pixel pairs, of each sprite in the pixel store.
    localparam int DEF_BG_BASE     = 0;
    localparam int DEF_PWR_BASE    = 64800;
    localparam int DEF_RED_BASE    = 65000;
    localparam int DEF_GREEN_BASE  = 79112;
    localparam int DEF_BLUE_BASE   = 93224;
    localparam int DEF_YELLOW_BASE = 107336;
    localparam int DEF_WIN_BASE    = 121448;
    localparam int DEF_LOSE_BASE   = 143048;

    // Number of pixel pairs in each sprite.
    localparam logic [15:0] BG_LIMIT    = 16'd64800;
    localparam logic [15:0] PWR_LIMIT   = 16'd200;
    localparam logic [15:0] COLOR_LIMIT = 16'd14112;
    localparam logic [15:0] WIN_LIMIT   = 16'd21600;
    localparam logic [15:0] LOSE_LIMIT  = 16'd25200;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_HI  = 2'd1,
        RD_LO  = 2'd2,
        CAP_LO = 2'd3
    } state_e;

    function automatic logic [15:0] pair_limit(input logic [2:0] sel);
        case (sel)
            SEL_BG:   pair_limit = BG_LIMIT;
            SEL_PWR:  pair_limit = PWR_LIMIT;
            SEL_WIN:  pair_limit = WIN_LIMIT;
            SEL_LOSE: pair_limit = LOSE_LIMIT;
            default:  pair_limit = COLOR_LIMIT;
        endcase
    endfunction

endpackage

// File: rtl/sprite_mem_server_if.sv
// Loader-side bus of the sprite memory server.
//   MEM_CLK    : pair-read request strobe (request on its rising edge)
//   MEM_ADDR   : pair index within the sprite
//   MEM_SEL    : sprite select
//   DATA_OUT   : pixel pair, [47:24] first pixel, [23:0] second pixel
//   DATA_VALID : DATA_OUT answers the last accepted request
// master = sprite loader, slave = sprite memory server.
interface sprite_mem_server_if;
    logic        MEM_CLK;
    logic [15:0] MEM_ADDR;
    logic [2:0]  MEM_SEL;
    logic [47:0] DATA_OUT;
    logic        DATA_VALID;

    modport master (
        output MEM_CLK, MEM_ADDR, MEM_SEL,
        input  DATA_OUT, DATA_VALID
    );

    modport slave (
        input  MEM_CLK, MEM_ADDR, MEM_SEL,
        output DATA_OUT, DATA_VALID
    );
endinterface

// File: rtl/sprite_addr_map.sv
// Combinational sprite address map.
//   sel      : sprite select
//   addr     : pair index within the sprite
//   pair_sum : base(sel) + addr, absolute pair index in the pixel store
//   in_range : addr is below the pair count of the selected sprite
module sprite_addr_map
    import sprite_mem_server_pkg::*;
#(
    parameter int ROM_AW      = 19,
    parameter int BG_BASE     = DEF_BG_BASE,
    parameter int PWR_BASE    = DEF_PWR_BASE,
    parameter int RED_BASE    = DEF_RED_BASE,
    parameter int GREEN_BASE  = DEF_GREEN_BASE,
    parameter int BLUE_BASE   = DEF_BLUE_BASE,
    parameter int YELLOW_BASE = DEF_YELLOW_BASE,
    parameter int WIN_BASE    = DEF_WIN_BASE,
    parameter int LOSE_BASE   = DEF_LOSE_BASE
) (
    input  logic [2:0]        sel,
    input  logic [15:0]       addr,
    output logic [ROM_AW-1:0] pair_sum,
    output logic              in_range
);

    logic [ROM_AW-1:0] base;

    always_comb begin
        base = '0;
        case (sel)
            SEL_BG:     base = ROM_AW'(BG_BASE);
            SEL_PWR:    base = ROM_AW'(PWR_BASE);
            SEL_RED:    base = ROM_AW'(RED_BASE);
            SEL_GREEN:  base = ROM_AW'(GREEN_BASE);
            SEL_BLUE:   base = ROM_AW'(BLUE_BASE);
            SEL_YELLOW: base = ROM_AW'(YELLOW_BASE);
            SEL_WIN:    base = ROM_AW'(WIN_BASE);
            default:    base = ROM_AW'(LOSE_BASE);
        endcase
        pair_sum = base + ROM_AW'(addr);
        in_range = (addr < pair_limit(sel));
    end

endmodule

// File: rtl/sprite_mem_server.sv
// Sprite memory server: answers one pixel-pair request from the sprite
// loader by reading two consecutive 24-bit words from the pixel store.
//   CLK, RESET_N : clock, asynchronous active-low reset
//   bus          : loader bus (request strobe/address/select, pair + valid)
//   ROM_RD       : pixel-store read enable
//   ROM_ADDR     : pixel-store word address, 2*(base+addr) then +1
//   ROM_DATA     : pixel-store data, one cycle after ROM_RD
//   ADDR_ERR     : sticky, a request addressed beyond its sprite
//   OVERRUN      : sticky, a request arrived while a read was in progress
module sprite_mem_server
    import sprite_mem_server_pkg::*;
#(
    parameter int ROM_AW      = 19,
    parameter int BG_BASE     = DEF_BG_BASE,
    parameter int PWR_BASE    = DEF_PWR_BASE,
    parameter int RED_BASE    = DEF_RED_BASE,
    parameter int GREEN_BASE  = DEF_GREEN_BASE,
    parameter int BLUE_BASE   = DEF_BLUE_BASE,
    parameter int YELLOW_BASE = DEF_YELLOW_BASE,
    parameter int WIN_BASE    = DEF_WIN_BASE,
    parameter int LOSE_BASE   = DEF_LOSE_BASE
) (
    input  logic                CLK,
    input  logic                RESET_N,
    sprite_mem_server_if.slave  bus,
    output logic                ROM_RD,
    output logic [ROM_AW-1:0]   ROM_ADDR,
    input  logic [23:0]         ROM_DATA,
    output logic                ADDR_ERR,
    output logic                OVERRUN
);

    state_e            state, state_nxt;
    logic              mem_clk_q;
    logic              req;
    logic [2:0]        sel_q;
    logic [15:0]       addr_q;
    logic [23:0]       first_px;
    logic [ROM_AW-1:0] pair_sum;
    logic              in_range;

    // The loader strobe is slow and asynchronous to our intent; a request is
    // its low-to-high transition as seen across one CLK.
    assign req = bus.MEM_CLK & ~mem_clk_q;

    sprite_addr_map #(
        .ROM_AW      (ROM_AW),
        .BG_BASE     (BG_BASE),
        .PWR_BASE    (PWR_BASE),
        .RED_BASE    (RED_BASE),
        .GREEN_BASE  (GREEN_BASE),
        .BLUE_BASE   (BLUE_BASE),
        .YELLOW_BASE (YELLOW_BASE),
        .WIN_BASE    (WIN_BASE),
        .LOSE_BASE   (LOSE_BASE)
    ) u_addr_map (
        .sel      (sel_q),
        .addr     (addr_q),
        .pair_sum (pair_sum),
        .in_range (in_range)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ROM_RD    = 1'b0;
        ROM_ADDR  = '0;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = RD_HI;
                end
            end
            RD_HI: begin
                ROM_RD    = in_range;
                ROM_ADDR  = in_range ? (pair_sum << 1) : '0;
                state_nxt = RD_LO;
            end
            RD_LO: begin
                ROM_RD    = in_range;
                ROM_ADDR  = in_range ? ((pair_sum << 1) | ROM_AW'(1)) : '0;
                state_nxt = CAP_LO;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // History resets high so a strobe held high through reset is not a request.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            mem_clk_q      <= 1'b1;
            bus.DATA_OUT   <= '0;
            bus.DATA_VALID <= 1'b0;
            ADDR_ERR       <= 1'b0;
            OVERRUN        <= 1'b0;
        end else begin
            mem_clk_q <= bus.MEM_CLK;
            if (req && state == IDLE) begin
                bus.DATA_VALID <= 1'b0;
            end
            if (req && state != IDLE) begin
                OVERRUN <= 1'b1;
            end
            if (state == RD_HI && !in_range) begin
                ADDR_ERR <= 1'b1;
            end
            if (state == CAP_LO) begin
                bus.DATA_OUT   <= in_range ? {first_px, ROM_DATA} : '0;
                bus.DATA_VALID <= 1'b1;
            end
        end
    end

    // Request parameters and the first pixel need no reset: they are only
    // consumed in states reachable after a fresh request.
    always_ff @(posedge CLK) begin
        if (req && state == IDLE) begin
            sel_q  <= bus.MEM_SEL;
            addr_q <= bus.MEM_ADDR;
        end
        if (state == RD_LO) begin
            first_px <= ROM_DATA;
        end
    end

endmodule

// File: tb/tb_sprite_mem_server.sv
// Directed bench for sprite_mem_server: a table of single-request vectors
// plus hand-written overrun, reset-mid-read and hold sequences.
module tb_sprite_mem_server;

    logic        clk;
    logic        rst_n;
    logic        rom_rd;
    logic [18:0] rom_addr;
    logic [23:0] rom_data;
    logic        addr_err;
    logic        overrun;

    int checks;
    int failures;

    sprite_mem_server_if bus();

    sprite_mem_server dut (
        .CLK      (clk),
        .RESET_N  (rst_n),
        .bus      (bus),
        .ROM_RD   (rom_rd),
        .ROM_ADDR (rom_addr),
        .ROM_DATA (rom_data),
        .ADDR_ERR (addr_err),
        .OVERRUN  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pixel-store contents: two fixed words, every other word unique per address.
    function automatic logic [23:0] rom_word(input logic [18:0] a);
        if (a == 19'd10) return 24'h112233;
        if (a == 19'd11) return 24'h445566;
        return {5'h15, a} ^ 24'h003C3C;
    endfunction

    always @(posedge clk) begin
        if (rom_rd) rom_data <= rom_word(rom_addr);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  sel;
        logic [15:0] addr;
        logic        exp_rd;
        logic [18:0] exp_hi;
        logic [18:0] exp_lo;
        logic [47:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t        vecs[11];
    logic [47:0] last_data;

    task automatic run_req(input vec_t v, input string tag);
        @(negedge clk) bus.MEM_CLK = 1'b0;
        @(negedge clk);
        bus.MEM_SEL  = v.sel;
        bus.MEM_ADDR = v.addr;
        bus.MEM_CLK  = 1'b1;
        @(negedge clk);  // RD_HI
        chk({tag, " hi_rd"}, 64'(rom_rd), 64'(v.exp_rd));
        if (v.exp_rd) chk({tag, " hi_addr"}, 64'(rom_addr), 64'(v.exp_hi));
        chk({tag, " valid_drop"}, 64'(bus.DATA_VALID), 64'd0);
        chk({tag, " data_hold"}, 64'(bus.DATA_OUT), 64'(last_data));
        @(negedge clk);  // RD_LO
        chk({tag, " lo_rd"}, 64'(rom_rd), 64'(v.exp_rd));
        if (v.exp_rd) chk({tag, " lo_addr"}, 64'(rom_addr), 64'(v.exp_lo));
        @(negedge clk);  // CAP_LO
        chk({tag, " cap_rd"}, 64'(rom_rd), 64'd0);
        chk({tag, " cap_valid"}, 64'(bus.DATA_VALID), 64'd0);
        @(negedge clk);  // IDLE, answer delivered
        chk({tag, " valid"}, 64'(bus.DATA_VALID), 64'd1);
        chk({tag, " data"}, 64'(bus.DATA_OUT), 64'(v.exp_data));
        chk({tag, " addr_err"}, 64'(addr_err), 64'(v.exp_err));
        last_data = bus.DATA_OUT;
    endtask

    function automatic vec_t mk(input logic [2:0] s, input logic [15:0] a, input logic rd,
                                input logic [18:0] hi, input logic err);
        vec_t v;
        v.sel = s; v.addr = a; v.exp_rd = rd; v.exp_hi = hi; v.exp_lo = hi + 19'd1;
        v.exp_data = rd ? {rom_word(hi), rom_word(hi + 19'd1)} : 48'd0;
        v.exp_err = err;
        return v;
    endfunction

    initial begin
        vec_t v;
        checks = 0;
        failures = 0;
        last_data = '0;
        bus.MEM_CLK = 1'b1;
        bus.MEM_ADDR = '0;
        bus.MEM_SEL = '0;
        rst_n = 1'b0;

        vecs[0]  = mk(3'b000, 16'd5,     1'b1, 19'd10,     1'b0);
        vecs[0].exp_data = 48'h112233445566;
        vecs[1]  = mk(3'b111, 16'd25199, 1'b1, 19'd336494, 1'b0);
        vecs[2]  = mk(3'b001, 16'd199,   1'b1, 19'd129998, 1'b0);
        vecs[3]  = mk(3'b010, 16'd0,     1'b1, 19'd130000, 1'b0);
        vecs[4]  = mk(3'b011, 16'd100,   1'b1, 19'd158424, 1'b0);
        vecs[5]  = mk(3'b100, 16'd14111, 1'b1, 19'd214670, 1'b0);
        vecs[6]  = mk(3'b101, 16'd7,     1'b1, 19'd214686, 1'b0);
        vecs[7]  = mk(3'b110, 16'd21599, 1'b1, 19'd286094, 1'b0);
        vecs[8]  = mk(3'b001, 16'd200,   1'b0, 19'd0,      1'b1);
        vecs[9]  = mk(3'b111, 16'd25200, 1'b0, 19'd0,      1'b1);
        vecs[10] = mk(3'b000, 16'd64800, 1'b0, 19'd0,      1'b1);

        // Reset state, strobe held high throughout
        repeat (2) @(negedge clk);
        chk("rst data", 64'(bus.DATA_OUT), 64'd0);
        chk("rst valid", 64'(bus.DATA_VALID), 64'd0);
        chk("rst rom_rd", 64'(rom_rd), 64'd0);
        chk("rst rom_addr", 64'(rom_addr), 64'd0);
        chk("rst flags", 64'({addr_err, overrun}), 64'd0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst no_req", 64'(rom_rd), 64'd0);
        end

        for (int i = 0; i < 11; i++) begin
            run_req(vecs[i], $sformatf("vec%0d", i));
            chk($sformatf("vec%0d overrun", i), 64'(overrun), 64'd0);
        end

        // Overrun: second edge in RD_LO with an out-of-range target
        bus.MEM_CLK = 1'b0;
        @(negedge clk);
        bus.MEM_SEL = 3'b010; bus.MEM_ADDR = 16'd3; bus.MEM_CLK = 1'b1;
        @(negedge clk);  // RD_HI
        chk("ovr hi_addr", 64'(rom_addr), 64'd130006);
        bus.MEM_CLK = 1'b0;
        @(negedge clk);  // RD_LO
        chk("ovr lo_addr", 64'(rom_addr), 64'd130007);
        bus.MEM_SEL = 3'b001; bus.MEM_ADDR = 16'd500; bus.MEM_CLK = 1'b1;
        @(negedge clk);  // CAP_LO
        chk("ovr flag", 64'(overrun), 64'd1);
        @(negedge clk);
        chk("ovr valid", 64'(bus.DATA_VALID), 64'd1);
        chk("ovr data", 64'(bus.DATA_OUT), 64'({rom_word(19'd130006), rom_word(19'd130007)}));
        last_data = bus.DATA_OUT;
        @(negedge clk);
        chk("ovr no_restart", 64'(rom_rd), 64'd0);

        // Hold: strobe static for 100 cycles
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i % 10 == 9) chk($sformatf("hold%0d", i),
                                 64'({bus.DATA_VALID, bus.DATA_OUT}), 64'({1'b1, last_data}));
        end

        // Reset mid-read with strobe held high
        bus.MEM_CLK = 1'b0;
        @(negedge clk);
        bus.MEM_SEL = 3'b000; bus.MEM_ADDR = 16'd5; bus.MEM_CLK = 1'b1;
        @(negedge clk);  // RD_HI
        @(negedge clk);  // RD_LO
        chk("mid rd_lo", 64'(rom_rd), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid rst outs", 64'({bus.DATA_VALID, rom_rd, addr_err, overrun}), 64'd0);
        chk("mid rst data", 64'(bus.DATA_OUT), 64'd0);
        chk("mid rst addr", 64'(rom_addr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("mid no_req", 64'({rom_rd, bus.DATA_VALID}), 64'd0);
        end
        last_data = '0;
        v = vecs[0];
        v.exp_err = 1'b0;
        run_req(v, "after_rst");
        chk("after_rst overrun", 64'(overrun), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
